vx_operand_collector: RTL and testbench

//  Banked GPR operand collector for one issue slice, generalised over source count, bank count and warps.

---
 rtl/vx_operand_collector_if.sv | 45 ++++
 rtl/vx_operand_collector.sv | 180 ++++++++++++++++++
 tb/tb_vx_operand_collector.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_operand_collector_if.sv
// Request, writeback and response bundle of the banked GPR operand collector.
// The master drives requests and writebacks and consumes operands; the collector is the slave.
interface vx_operand_collector_if #(
    parameter int NUM_SRCS      = 3,
    parameter int NR_W          = 5,
    parameter int WID_W         = 2,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int META_W        = 64,
    parameter int PERF_CTR_BITS = 44
);
    localparam int REG_W = NUM_THREADS * XLEN;

    logic                         req_valid;
    logic                         req_ready;
    logic [WID_W-1:0]             req_wid;
    logic [NUM_SRCS*NR_W-1:0]     req_rs;
    logic [META_W-1:0]            req_meta;

    logic                         wb_valid;
    logic [WID_W-1:0]             wb_wid;
    logic [NR_W-1:0]              wb_rd;
    logic [NUM_THREADS-1:0]       wb_tmask;
    logic [REG_W-1:0]             wb_data;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [META_W-1:0]            rsp_meta;
    logic [NUM_SRCS*REG_W-1:0]    rsp_data;
    logic [PERF_CTR_BITS-1:0]     collisions;

    modport master (
        output req_valid, req_wid, req_rs, req_meta,
        output wb_valid, wb_wid, wb_rd, wb_tmask, wb_data,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_meta, rsp_data, collisions
    );

    modport slave (
        input  req_valid, req_wid, req_rs, req_meta,
        input  wb_valid, wb_wid, wb_rd, wb_tmask, wb_data,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_meta, rsp_data, collisions
    );
endinterface

// File: rtl/vx_operand_collector.sv
// Banked GPR operand collector: gathers all source operands of one request, serialising
// bank conflicts over extra read rounds and forwarding writebacks that hit the read-issue cycle.
module vx_operand_collector #(
    parameter int NUM_SRCS      = 3,
    parameter int NUM_BANKS     = 4,
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 32,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int META_W        = 64,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_operand_collector_if.slave  bus
);
    localparam int NR_W  = $clog2(NUM_REGS);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int REG_W = NUM_THREADS * XLEN;
    localparam int LOG_B = $clog2(NUM_BANKS);
    localparam int BK_W  = (NUM_BANKS > 1) ? LOG_B : 1;
    localparam int ROWS  = (NUM_REGS / NUM_BANKS) * NUM_WARPS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, OUT = 2'd2} state_t;

    state_t                              r_state;
    state_t                              w_stateNext;
    logic [NUM_SRCS-1:0][NR_W-1:0]       r_rs;
    logic [WID_W-1:0]                    r_wid;
    logic [META_W-1:0]                   r_meta;
    logic [NUM_SRCS-1:0]                 r_pending;
    logic [NUM_SRCS-1:0]                 r_granted;
    logic [NUM_SRCS-1:0][REG_W-1:0]      r_ops;
    logic [PERF_CTR_BITS-1:0]            r_collisions;

    logic                                w_reqFire;
    logic [NUM_SRCS-1:0]                 w_srcNonZero;
    logic [NUM_SRCS-1:0]                 w_grant;
    logic [NUM_SRCS-1:0]                 w_pendNext;
    logic [NUM_SRCS-1:0][BK_W-1:0]       w_bank;
    logic [NUM_SRCS-1:0][ROW_W-1:0]      w_row;
    logic [NUM_BANKS-1:0]                w_rdEn;
    logic [NUM_BANKS-1:0][ROW_W-1:0]     w_rdRow;
    logic [REG_W-1:0]                    w_rdata [NUM_BANKS];
    logic                                w_wbEn;
    logic [BK_W-1:0]                     w_wbBank;
    logic [ROW_W-1:0]                    w_wbRow;

    function automatic logic [BK_W-1:0] bankOf(input logic [NR_W-1:0] rs);
        return BK_W'(rs & NR_W'(NUM_BANKS - 1));
    endfunction

    // Row = {rs >> log2(banks), wid}, built arithmetically so single-warp configs drop the wid.
    function automatic logic [ROW_W-1:0] rowOf(input logic [NR_W-1:0] rs, input logic [WID_W-1:0] wid);
        logic [31:0] row;
        row = (32'(rs) >> LOG_B) * 32'(NUM_WARPS);
        if (NUM_WARPS > 1) row = row + 32'(wid);
        return ROW_W'(row);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_stateNext = READ;
            READ:    if (r_pending == '0) w_stateNext = OUT;
            OUT:     if (bus.rsp_ready) w_stateNext = bus.req_valid ? READ : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: bus.req_ready = reset_n;
            OUT: begin
                bus.rsp_valid = 1'b1;
                bus.req_ready = bus.rsp_ready && reset_n;
            end
            default: ;
        endcase
    end

    assign w_reqFire      = bus.req_valid && bus.req_ready;
    assign bus.rsp_data   = r_ops;
    assign bus.rsp_meta   = r_meta;
    assign bus.collisions = r_collisions;

    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            w_srcNonZero[i] = (bus.req_rs[i*NR_W +: NR_W] != '0);
            w_bank[i]       = bankOf(r_rs[i]);
            w_row[i]        = rowOf(r_rs[i], r_wid);
        end
    end

    // Each bank serves the lowest-index pending source mapped to it this round.
    always_comb begin
        w_rdEn  = '0;
        w_rdRow = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            w_grant[i] = (r_state == READ) && r_pending[i];
            for (int j = 0; j < i; j++) begin
                if (r_pending[j] && (w_bank[j] == w_bank[i])) w_grant[i] = 1'b0;
            end
        end
        w_pendNext = r_pending & ~w_grant;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (w_grant[i]) begin
                w_rdEn[w_bank[i]]  = 1'b1;
                w_rdRow[w_bank[i]] = w_row[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs         <= '0;
            r_wid        <= '0;
            r_meta       <= '0;
            r_pending    <= '0;
            r_granted    <= '0;
            r_ops        <= '0;
            r_collisions <= '0;
        end else if (w_reqFire) begin
            r_rs      <= bus.req_rs;
            r_wid     <= bus.req_wid;
            r_meta    <= bus.req_meta;
            r_pending <= w_srcNonZero;
            r_granted <= '0;
            r_ops     <= '0;
        end else if (r_state == READ) begin
            r_pending <= w_pendNext;
            r_granted <= w_grant;
            for (int i = 0; i < NUM_SRCS; i++) begin
                if (r_granted[i]) r_ops[i] <= w_rdata[w_bank[i]];
            end
            if ((w_pendNext != '0) && (r_collisions != '1))
                r_collisions <= r_collisions + PERF_CTR_BITS'(1);
        end
    end

    assign w_wbEn   = bus.wb_valid && (bus.wb_rd != '0);
    assign w_wbBank = bankOf(bus.wb_rd);
    assign w_wbRow  = rowOf(bus.wb_rd, bus.wb_wid);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [REG_W-1:0] r_mem [ROWS];
        logic [REG_W-1:0] r_rdata;
        logic [REG_W-1:0] w_fwd;
        logic             w_wrHere;

        assign w_wrHere = w_wbEn && (w_wbBank == BK_W'(b));

        // Write-first bypass so a same-cycle writeback is seen by the read it collides with.
        always_comb begin
            w_fwd = r_mem[w_rdRow[b]];
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (w_wrHere && (w_wbRow == w_rdRow[b]) && bus.wb_tmask[l])
                    w_fwd[l*XLEN +: XLEN] = bus.wb_data[l*XLEN +: XLEN];
            end
        end

        always_ff @(posedge clk) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (w_wrHere && bus.wb_tmask[l])
                    r_mem[w_wbRow][l*XLEN +: XLEN] <= bus.wb_data[l*XLEN +: XLEN];
            end
            if (w_rdEn[b]) r_rdata <= w_fwd;
        end

        assign w_rdata[b] = r_rdata;
    end
endmodule

// File: tb/tb_vx_operand_collector.sv
// Self-checking bench for vx_operand_collector: table of request vectors plus hand-written
// sequences for forwarding, back-pressure and mid-read reset, with a response scoreboard.
module tb_vx_operand_collector;
    localparam int NUM_SRCS    = 3;
    localparam int NUM_BANKS   = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NUM_REGS    = 32;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int META_W      = 64;
    localparam int PCB         = 44;
    localparam int NR_W        = 5;
    localparam int WID_W       = 2;
    localparam int REG_W       = NUM_THREADS * XLEN;
    localparam int DW          = NUM_SRCS * REG_W;
    localparam int NVEC        = 9;

    typedef struct {
        logic [WID_W-1:0]  wid;
        logic [NR_W-1:0]   rs0;
        logic [NR_W-1:0]   rs1;
        logic [NR_W-1:0]   rs2;
        logic [META_W-1:0] meta;
        int                lat;
        int                coll;
    } vec_t;

    typedef struct {
        logic [META_W-1:0] meta;
        logic [DW-1:0]     data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vx_operand_collector_if #(
        .NUM_SRCS(NUM_SRCS), .NR_W(NR_W), .WID_W(WID_W), .NUM_THREADS(NUM_THREADS),
        .XLEN(XLEN), .META_W(META_W), .PERF_CTR_BITS(PCB)
    ) busIf ();

    vx_operand_collector #(
        .NUM_SRCS(NUM_SRCS), .NUM_BANKS(NUM_BANKS), .NUM_WARPS(NUM_WARPS), .NUM_REGS(NUM_REGS),
        .NUM_THREADS(NUM_THREADS), .XLEN(XLEN), .META_W(META_W), .PERF_CTR_BITS(PCB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(busIf)
    );

    vec_t             vecs [NVEC];
    exp_t             sbQ [$];
    exp_t             monE;
    logic [REG_W-1:0] model [NUM_WARPS][NUM_REGS];
    logic [PCB-1:0]   expColl = '0;
    int               nCompared = 0;
    int               nFailed = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REG_W-1:0] pat(input int w, input int r);
        logic [REG_W-1:0] d;
        for (int l = 0; l < NUM_THREADS; l++) d[l*XLEN +: XLEN] = {8'(w), 8'(r), 8'(l), 8'h5A};
        return d;
    endfunction

    function automatic logic [DW-1:0] expOps(input vec_t v);
        logic [NR_W-1:0] rs [NUM_SRCS];
        logic [DW-1:0]   d;
        rs[0] = v.rs0;
        rs[1] = v.rs1;
        rs[2] = v.rs2;
        d = '0;
        for (int i = 0; i < NUM_SRCS; i++)
            if (rs[i] != '0) d[i*REG_W +: REG_W] = model[v.wid][rs[i]];
        return d;
    endfunction

    task automatic doWrite(input int w, input int r, input logic [NUM_THREADS-1:0] tm, input logic [REG_W-1:0] data);
        busIf.wb_valid = 1'b1;
        busIf.wb_wid   = WID_W'(w);
        busIf.wb_rd    = NR_W'(r);
        busIf.wb_tmask = tm;
        busIf.wb_data  = data;
        if (r != 0)
            for (int l = 0; l < NUM_THREADS; l++)
                if (tm[l]) model[w][r][l*XLEN +: XLEN] = data[l*XLEN +: XLEN];
        tick();
        busIf.wb_valid = 1'b0;
    endtask

    // Leaves the bench one cycle after the accepting edge, i.e. in cycle T+1.
    task automatic applyStimulus(input vec_t v, input bit autoPush);
        bit   fired;
        exp_t e;
        fired = 1'b0;
        busIf.req_valid = 1'b1;
        busIf.req_wid   = v.wid;
        busIf.req_rs    = {v.rs2, v.rs1, v.rs0};
        busIf.req_meta  = v.meta;
        for (int k = 0; k < 20 && !fired; k++) begin
            if (busIf.req_ready) fired = 1'b1;
            tick();
        end
        busIf.req_valid = 1'b0;
        if (!fired) checkOutput("req_accept", DW'(0), DW'(1));
        if (autoPush) begin
            e.meta = v.meta;
            e.data = expOps(v);
            sbQ.push_back(e);
        end
    endtask

    task automatic waitRsp(input int expLat, input int startLat, input string name);
        int lat;
        bit seen;
        lat  = startLat;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            if (busIf.rsp_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, DW'(0), DW'(1));
        else       checkOutput({name, "_lat"}, DW'(lat), DW'(expLat));
    endtask

    always @(negedge clk) begin
        if (reset_n && busIf.rsp_valid && busIf.rsp_ready) begin
            if (sbQ.size() == 0) checkOutput("unexpected_rsp", DW'(1), DW'(0));
            else begin
                monE = sbQ.pop_front();
                checkOutput("rsp_data", busIf.rsp_data, monE.data);
                checkOutput("rsp_meta", DW'(busIf.rsp_meta), DW'(monE.meta));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        exp_t e;
        logic [DW-1:0] held;

        busIf.req_valid = 1'b0;
        busIf.req_wid   = '0;
        busIf.req_rs    = '0;
        busIf.req_meta  = '0;
        busIf.wb_valid  = 1'b0;
        busIf.wb_wid    = '0;
        busIf.wb_rd     = '0;
        busIf.wb_tmask  = '0;
        busIf.wb_data   = '0;
        busIf.rsp_ready = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++)
            for (int r = 0; r < NUM_REGS; r++) model[w][r] = '0;

        vecs[0] = '{2'd1, 5'd5,  5'd6,  5'd7,  64'h1000, 3, 0};
        vecs[1] = '{2'd0, 5'd4,  5'd8,  5'd12, 64'h1001, 5, 2};
        vecs[2] = '{2'd2, 5'd0,  5'd0,  5'd0,  64'hDEAD, 2, 0};
        vecs[3] = '{2'd3, 5'd1,  5'd5,  5'd9,  64'h1003, 5, 2};
        vecs[4] = '{2'd0, 5'd2,  5'd3,  5'd6,  64'h1004, 4, 1};
        vecs[5] = '{2'd1, 5'd0,  5'd4,  5'd8,  64'h1005, 4, 1};
        vecs[6] = '{2'd2, 5'd31, 5'd30, 5'd29, 64'h1006, 3, 0};
        vecs[7] = '{2'd3, 5'd7,  5'd7,  5'd7,  64'h1007, 5, 2};
        vecs[8] = '{2'd0, 5'd0,  5'd0,  5'd13, 64'h1008, 3, 0};

        #2;
        checkOutput("rst_rsp_valid", DW'(busIf.rsp_valid), DW'(0));
        checkOutput("rst_req_ready", DW'(busIf.req_ready), DW'(0));
        checkOutput("rst_collisions", DW'(busIf.collisions), DW'(0));
        checkOutput("rst_rsp_data", busIf.rsp_data, DW'(0));
        checkOutput("rst_rsp_meta", DW'(busIf.rsp_meta), DW'(0));
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("idle_req_ready", DW'(busIf.req_ready), DW'(1));

        for (int w = 0; w < NUM_WARPS; w++)
            for (int r = 1; r < NUM_REGS; r++) doWrite(w, r, 4'hF, pat(w, r));
        doWrite(1, 5,  4'hF, {4{32'h05050505}});
        doWrite(1, 6,  4'hF, {4{32'h06060606}});
        doWrite(1, 7,  4'hF, {4{32'h07070707}});
        doWrite(0, 4,  4'hF, {4{32'h000000A4}});
        doWrite(0, 8,  4'hF, {4{32'h000000A8}});
        doWrite(0, 12, 4'hF, {4{32'h000000AC}});
        doWrite(0, 0,  4'hF, '1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], 1'b1);
            waitRsp(vecs[i].lat, 1, $sformatf("vec%0d", i));
            tick();
            expColl += PCB'(vecs[i].coll);
            checkOutput($sformatf("vec%0d_coll", i), DW'(busIf.collisions), DW'(expColl));
        end

        // Writeback in the read-issue cycle forwards per lane; a later write does not.
        doWrite(0, 9, 4'hF, {4{32'h11111111}});
        v = '{2'd0, 5'd9, 5'd0, 5'd0, 64'h4444, 3, 0};
        applyStimulus(v, 1'b0);
        e.meta = v.meta;
        e.data = {256'h0, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222};
        sbQ.push_back(e);
        busIf.wb_valid = 1'b1;
        busIf.wb_wid   = 2'd0;
        busIf.wb_rd    = 5'd9;
        busIf.wb_tmask = 4'b0101;
        busIf.wb_data  = {4{32'h22222222}};
        tick();
        busIf.wb_tmask = 4'hF;
        busIf.wb_data  = {4{32'h33333333}};
        tick();
        busIf.wb_valid = 1'b0;
        model[0][9] = {4{32'h33333333}};
        waitRsp(3, 3, "fwd");
        tick();
        applyStimulus(v, 1'b1);
        waitRsp(3, 1, "late_wb");
        tick();

        // Back-pressure: response held stable, then drained while the next request fires.
        busIf.rsp_ready = 1'b0;
        applyStimulus(vecs[0], 1'b1);
        held = expOps(vecs[0]);
        waitRsp(3, 1, "stall");
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall%0d_valid", k), DW'(busIf.rsp_valid), DW'(1));
            checkOutput($sformatf("stall%0d_ready", k), DW'(busIf.req_ready), DW'(0));
            checkOutput($sformatf("stall%0d_data", k), busIf.rsp_data, held);
            checkOutput($sformatf("stall%0d_meta", k), DW'(busIf.rsp_meta), DW'(vecs[0].meta));
            tick();
        end
        busIf.rsp_ready = 1'b1;
        #1;
        checkOutput("b2b_req_ready", DW'(busIf.req_ready), DW'(1));
        applyStimulus(vecs[6], 1'b1);
        waitRsp(3, 1, "b2b");
        tick();
        checkOutput("b2b_coll", DW'(busIf.collisions), DW'(expColl));

        // Reset during the READ of a colliding request drops it immediately.
        applyStimulus(vecs[1], 1'b0);
        tick();
        reset_n = 1'b0;
        #1;
        expColl = '0;
        checkOutput("midrst_rsp_valid", DW'(busIf.rsp_valid), DW'(0));
        checkOutput("midrst_req_ready", DW'(busIf.req_ready), DW'(0));
        checkOutput("midrst_collisions", DW'(busIf.collisions), DW'(expColl));
        checkOutput("midrst_rsp_data", busIf.rsp_data, DW'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("postrst_rsp_valid", DW'(busIf.rsp_valid), DW'(0));
        applyStimulus(vecs[0], 1'b1);
        waitRsp(3, 1, "postrst");
        tick();
        checkOutput("postrst_coll", DW'(busIf.collisions), DW'(expColl));
        checkOutput("sb_empty", DW'(sbQ.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
